// File: rtl/trap_controller.sv
// Trap sequencer in front of the CSR exception unit: arbitrates exceptions, interrupts, mret and wfi.
// Optional macro TRAP_CTRL_WFI_EN implements the WFI stall state; otherwise wfi is a NOP that pulses wfi_wake.
module trap_controller #(
  parameter int SYNC_STAGES = 2  // legal range 2..4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic [3:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        insn_boundary,
  input  logic [31:0] next_pc,
  input  logic        mret_req,
  input  logic        wfi_req,
  input  logic        mstatus_mie,
  input  logic [31:0] mie,
  input  logic [31:0] mip,
  input  logic        irq_ext,
  output logic        meip,
  output logic        exception_event,
  output logic        mret,
  output logic [31:0] cause,
  output logic [31:0] pc,
  output logic [31:0] badaddr,
  output logic        busy,
  output logic        trap_done,
  output logic        wfi_stall,
  output logic        wfi_wake
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRAP,
    S_MRET,
    S_REDIRECT,
    S_WFI
  } state_t;

  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [31:0] cause_reg, pc_reg, badaddr_reg;
  logic        wake_reg, wake_next;
  logic        load_exc, load_irq;
  logic [31:0] pending;
  logic        irq_take;
  logic [31:0] irq_cause;

  assign meip     = sync_reg[SYNC_STAGES-1];
  assign pending  = (mip | ({31'b0, meip} << 11)) & mie & 32'h0000_0888;
  assign irq_take = insn_boundary & mstatus_mie & (|pending);

  // Fixed interrupt priority: external, then software, then timer.
  always_comb begin
    irq_cause = 32'h8000_0007;
    if (pending[11])
      irq_cause = 32'h8000_000B;
    else if (pending[3])
      irq_cause = 32'h8000_0003;
  end

  always_comb begin
    state_next = state_reg;
    load_exc   = 1'b0;
    load_irq   = 1'b0;
    wake_next  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (exc_valid) begin
          state_next = S_TRAP;
          load_exc   = 1'b1;
        end else if (irq_take) begin
          state_next = S_TRAP;
          load_irq   = 1'b1;
        end else if (mret_req) begin
          state_next = S_MRET;
        end else if (wfi_req) begin
`ifdef TRAP_CTRL_WFI_EN
          state_next = S_WFI;
`else
          wake_next  = 1'b1;
`endif
        end
      end
      S_TRAP:     state_next = S_REDIRECT;
      S_MRET:     state_next = S_REDIRECT;
      S_REDIRECT: state_next = S_IDLE;
      S_WFI: begin
        // Wake ignores mstatus.MIE: any enabled pending source ends the stall.
        if (|pending) begin
          state_next = S_IDLE;
          wake_next  = 1'b1;
        end
      end
      default:    state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      wake_reg    <= 1'b0;
      sync_reg    <= '0;
      cause_reg   <= 32'b0;
      pc_reg      <= 32'b0;
      badaddr_reg <= 32'b0;
    end else begin
      state_reg <= state_next;
      wake_reg  <= wake_next;
      sync_reg  <= {sync_reg[SYNC_STAGES-2:0], irq_ext};
      if (load_exc) begin
        cause_reg   <= {28'b0, exc_code};
        pc_reg      <= exc_pc;
        badaddr_reg <= exc_tval;
      end else if (load_irq) begin
        cause_reg   <= irq_cause;
        pc_reg      <= next_pc;
        badaddr_reg <= 32'b0;
      end
    end
  end

  assign exception_event = (state_reg == S_TRAP);
  assign mret            = (state_reg == S_MRET);
  assign trap_done       = (state_reg == S_REDIRECT);
  assign busy            = (state_reg != S_IDLE);
  assign wfi_wake        = wake_reg;
`ifdef TRAP_CTRL_WFI_EN
  assign wfi_stall       = (state_reg == S_WFI);
`else
  assign wfi_stall       = 1'b0;
`endif
  assign cause           = cause_reg;
  assign pc              = pc_reg;
  assign badaddr         = badaddr_reg;

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: directed scenarios plus randomized transactions
// checked against a transaction-level priority model. Honours TRAP_CTRL_WFI_EN like the design.
module tb_trap_controller;
  localparam int S = 2;
  localparam int A_NONE = 0, A_EXC = 1, A_IRQ = 2, A_MRET = 3, A_WFI = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid, insn_boundary, mret_req, wfi_req, mstatus_mie, irq_ext;
  logic [3:0]  exc_code;
  logic [31:0] exc_pc, exc_tval, next_pc, mie, mip;
  logic        meip, exception_event, mret, busy, trap_done, wfi_stall, wfi_wake;
  logic [31:0] cause, pc, badaddr;
  logic [5:0]  ctl;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_cause, m_pc, m_badaddr;

  trap_controller #(.SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .exc_tval(exc_tval), .insn_boundary(insn_boundary), .next_pc(next_pc), .mret_req(mret_req),
    .wfi_req(wfi_req), .mstatus_mie(mstatus_mie), .mie(mie), .mip(mip), .irq_ext(irq_ext),
    .meip(meip), .exception_event(exception_event), .mret(mret), .cause(cause), .pc(pc),
    .badaddr(badaddr), .busy(busy), .trap_done(trap_done), .wfi_stall(wfi_stall), .wfi_wake(wfi_wake)
  );

  always #5 clk = ~clk;

  // {busy, exception_event, mret, trap_done, wfi_stall, wfi_wake}
  assign ctl = {busy, exception_event, mret, trap_done, wfi_stall, wfi_wake};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // Transaction-level reference: which request wins and what interrupt cause it would carry.
  function automatic void model(input logic ev, input logic mr, input logic wf, input logic ib,
                                input logic smie, input logic ext, input logic [31:0] mip_v,
                                input logic [31:0] mie_v, output int act,
                                output logic [31:0] icause, output logic pend_any);
    int id;
    logic hit;
    icause   = 32'h0;
    pend_any = 1'b0;
    for (int k = 0; k < 3; k++) begin
      id  = (k == 0) ? 11 : (k == 1) ? 3 : 7;
      hit = mie_v[id] && (mip_v[id] || (id == 11 && ext));
      if (hit && !pend_any) icause = 32'h8000_0000 | 32'(id);
      if (hit) pend_any = 1'b1;
    end
    if (ev) act = A_EXC;
    else if (ib && smie && pend_any) act = A_IRQ;
    else if (mr) act = A_MRET;
    else if (wf) act = A_WFI;
    else act = A_NONE;
  endfunction

  task automatic idle_inputs();
    exc_valid = 1'b0; mret_req = 1'b0; wfi_req = 1'b0; insn_boundary = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; irq_ext = 1'b1; exc_valid = 1'b1; mret_req = 1'b1; insn_boundary = 1'b1;
    mstatus_mie = 1'b1; mip = 32'h888; mie = 32'h888; exc_code = 4'd3; exc_pc = 32'h4;
    exc_tval = 32'h8; next_pc = 32'h0; wfi_req = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, 6'b0); end
    checks++; if ({cause, pc, badaddr} !== 96'b0) begin errors++; $display("FAIL reset_regs: got %h %h %h expected 0", cause, pc, badaddr); end
    checks++; if (meip !== 1'b0) begin errors++; $display("FAIL reset_meip: got %b expected 0", meip); end
    idle_inputs(); irq_ext = 1'b0; mip = 32'h0; mie = 32'h0; mstatus_mie = 1'b0;
    rst = 1'b0;
    repeat (S + 1) @(negedge clk);
    $display("txn reset done");
  endtask

  task automatic test_exception();
    exc_valid = 1'b1; exc_code = 4'd2; exc_pc = 32'h100; exc_tval = 32'hDEAD;
    @(negedge clk);
    idle_inputs();
    checks++; if (ctl !== 6'b110000) begin errors++; $display("FAIL exc_n1_ctl: got %b expected %b", ctl, 6'b110000); end
    checks++; if ({cause, pc, badaddr} !== {32'h2, 32'h100, 32'hDEAD}) begin errors++; $display("FAIL exc_regs: got %h %h %h expected 2 100 dead", cause, pc, badaddr); end
    @(negedge clk);
    checks++; if (ctl !== 6'b100100) begin errors++; $display("FAIL exc_n2_ctl: got %b expected %b", ctl, 6'b100100); end
    @(negedge clk);
    checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL exc_n3_ctl: got %b expected %b", ctl, 6'b0); end
    $display("txn exception cause=%h pc=%h badaddr=%h", cause, pc, badaddr);
  endtask

  task automatic test_irq_priority();
    mie = 32'h888; mip = 32'h0; mstatus_mie = 1'b1; insn_boundary = 1'b1; next_pc = 32'h200;
    irq_ext = 1'b1;
    for (int k = 1; k <= S; k++) begin
      @(negedge clk);
      checks++; if (exception_event !== 1'b0) begin errors++; $display("FAIL irq_early_%0d: got %b expected 0", k, exception_event); end
      checks++; if (meip !== (k == S)) begin errors++; $display("FAIL meip_lat_%0d: got %b expected %b", k, meip, (k == S)); end
    end
    @(negedge clk);
    insn_boundary = 1'b0; mip = 32'h88;
    checks++; if (ctl !== 6'b110000) begin errors++; $display("FAIL irq_lat_ctl: got %b expected %b", ctl, 6'b110000); end
    checks++; if ({cause, pc, badaddr} !== {32'h8000_000B, 32'h200, 32'h0}) begin errors++; $display("FAIL irq_mei_regs: got %h %h %h", cause, pc, badaddr); end
    repeat (2) @(negedge clk);
    insn_boundary = 1'b1; next_pc = 32'h240;
    @(negedge clk);
    insn_boundary = 1'b0;
    checks++; if ({ctl, cause, pc} !== {6'b110000, 32'h8000_000B, 32'h240}) begin errors++; $display("FAIL irq_prio_mei: got %b %h %h expected 110000 8000000b 240", ctl, cause, pc); end
    repeat (2) @(negedge clk);
    irq_ext = 1'b0;
    repeat (S + 1) @(negedge clk);
    insn_boundary = 1'b1; next_pc = 32'h300;
    @(negedge clk);
    insn_boundary = 1'b0;
    checks++; if ({ctl, cause, pc, badaddr} !== {6'b110000, 32'h8000_0003, 32'h300, 32'h0}) begin errors++; $display("FAIL irq_prio_msi: got %b %h %h %h", ctl, cause, pc, badaddr); end
    repeat (2) @(negedge clk);
    mie = 32'h0; mip = 32'h0; mstatus_mie = 1'b0;
    $display("txn irq priority cause=%h pc=%h", cause, pc);
  endtask

  task automatic test_masking_mret();
    mstatus_mie = 1'b0; mip = 32'h80; mie = 32'h80; insn_boundary = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL mask_no_trap_%0d: got %b expected 0", i, ctl); end
    end
    mret_req = 1'b1;
    @(negedge clk);
    idle_inputs();
    checks++; if (ctl !== 6'b101000) begin errors++; $display("FAIL mret_n1_ctl: got %b expected %b", ctl, 6'b101000); end
    checks++; if ({cause, pc, badaddr} !== {32'h8000_0003, 32'h300, 32'h0}) begin errors++; $display("FAIL mret_regs_kept: got %h %h %h", cause, pc, badaddr); end
    @(negedge clk);
    checks++; if (ctl !== 6'b100100) begin errors++; $display("FAIL mret_n2_ctl: got %b expected %b", ctl, 6'b100100); end
    @(negedge clk);
    checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL mret_n3_ctl: got %b expected 0", ctl); end
    mip = 32'h0; mie = 32'h0;
    $display("txn mret cause=%h", cause);
  endtask

  task automatic test_simultaneous();
    int ev_cnt, mret_cnt;
    mip = 32'h8; mie = 32'h8; mstatus_mie = 1'b1; insn_boundary = 1'b1;
    exc_valid = 1'b1; mret_req = 1'b1; exc_code = 4'd5; exc_pc = 32'h400; exc_tval = 32'hFFFF_FFFF;
    @(negedge clk);
    idle_inputs();
    checks++; if ({ctl, cause, pc, badaddr} !== {6'b110000, 32'h5, 32'h400, 32'hFFFF_FFFF}) begin errors++; $display("FAIL simul_first: got %b %h %h %h", ctl, cause, pc, badaddr); end
    ev_cnt = 1; mret_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ev_cnt += int'(exception_event); mret_cnt += int'(mret);
    end
    checks++; if (ev_cnt !== 1 || mret_cnt !== 0) begin errors++; $display("FAIL simul_counts: got ev=%0d mret=%0d expected ev=1 mret=0", ev_cnt, mret_cnt); end
    mip = 32'h0; mie = 32'h0; mstatus_mie = 1'b0;
    $display("txn simultaneous cause=%h", cause);
  endtask

  task automatic test_back_to_back();
    exc_valid = 1'b1; exc_code = 4'd1; exc_pc = 32'h10; exc_tval = 32'h0;
    @(negedge clk);
    checks++; if (ctl !== 6'b110000) begin errors++; $display("FAIL b2b_first: got %b expected %b", ctl, 6'b110000); end
    exc_code = 4'd9; exc_pc = 32'h20; exc_tval = 32'h99;
    @(negedge clk);
    checks++; if ({ctl, cause} !== {6'b100100, 32'h1}) begin errors++; $display("FAIL b2b_ignored_busy: got %b %h expected 100100 1", ctl, cause); end
    @(negedge clk);
    checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL b2b_idle_gap: got %b expected 0", ctl); end
    @(negedge clk);
    idle_inputs();
    checks++; if ({ctl, cause, pc, badaddr} !== {6'b110000, 32'h9, 32'h20, 32'h99}) begin errors++; $display("FAIL b2b_second: got %b %h %h %h", ctl, cause, pc, badaddr); end
    repeat (2) @(negedge clk);
    $display("txn back_to_back cause=%h", cause);
  endtask

  task automatic test_wfi();
    mie = 32'h0; mip = 32'h0; mstatus_mie = 1'b0;
    wfi_req = 1'b1;
    @(negedge clk);
    wfi_req = 1'b0;
`ifdef TRAP_CTRL_WFI_EN
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      checks++; if (ctl !== 6'b100010) begin errors++; $display("FAIL wfi_stall_%0d: got %b expected %b", i, ctl, 6'b100010); end
    end
    mip = 32'h80; mie = 32'h80;
    @(negedge clk);
    checks++; if (ctl !== 6'b000001) begin errors++; $display("FAIL wfi_wake: got %b expected %b", ctl, 6'b000001); end
`else
    checks++; if (ctl !== 6'b000001) begin errors++; $display("FAIL wfi_nop_wake: got %b expected %b", ctl, 6'b000001); end
`endif
    @(negedge clk);
    checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL wfi_after: got %b expected 0", ctl); end
    mip = 32'h0; mie = 32'h0;
    $display("txn wfi done");
  endtask

  task automatic test_reset_mid();
    exc_valid = 1'b1; exc_code = 4'd7; exc_pc = 32'h500; exc_tval = 32'h55;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    checks++; if (ctl !== 6'b100100) begin errors++; $display("FAIL rstmid_redirect: got %b expected %b", ctl, 6'b100100); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({ctl, cause, pc, badaddr} !== {6'b0, 96'b0}) begin errors++; $display("FAIL rstmid_after_redirect: got %b %h %h %h", ctl, cause, pc, badaddr); end
    rst = 1'b0;
`ifdef TRAP_CTRL_WFI_EN
    wfi_req = 1'b1;
    @(negedge clk);
    wfi_req = 1'b0;
    checks++; if (ctl !== 6'b100010) begin errors++; $display("FAIL rstmid_wfi_entry: got %b expected %b", ctl, 6'b100010); end
    rst = 1'b1; mip = 32'h80; mie = 32'h80;
`else
    mret_req = 1'b1;
    @(negedge clk);
    mret_req = 1'b0;
    checks++; if (ctl !== 6'b101000) begin errors++; $display("FAIL rstmid_mret_entry: got %b expected %b", ctl, 6'b101000); end
    rst = 1'b1;
`endif
    @(negedge clk);
    checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL rstmid_second: got %b expected 0", ctl); end
    rst = 1'b0; mip = 32'h0; mie = 32'h0;
    @(negedge clk);
    checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL rstmid_no_pulse: got %b expected 0", ctl); end
    m_cause = 32'h0; m_pc = 32'h0; m_badaddr = 32'h0;
    $display("txn reset mid-sequence done");
  endtask

  task automatic test_random();
    int act;
    logic [31:0] icause;
    logic pend_any;
    for (int t = 0; t < 200; t++) begin
      idle_inputs();
      irq_ext = 1'($urandom_range(0, 1));
      mip = $urandom; mie = $urandom;
      repeat (S + 1) @(negedge clk);
      exc_valid     = ($urandom_range(0, 3) == 0);
      mret_req      = ($urandom_range(0, 2) == 0);
      wfi_req       = ($urandom_range(0, 2) == 0);
      insn_boundary = 1'($urandom_range(0, 1));
      mstatus_mie   = 1'($urandom_range(0, 1));
      exc_code      = 4'($urandom);
      exc_pc        = $urandom;
      exc_tval      = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      next_pc       = $urandom;
      model(exc_valid, mret_req, wfi_req, insn_boundary, mstatus_mie, irq_ext, mip, mie, act, icause, pend_any);
      if (act == A_EXC) begin m_cause = {28'b0, exc_code}; m_pc = exc_pc; m_badaddr = exc_tval; end
      if (act == A_IRQ) begin m_cause = icause; m_pc = next_pc; m_badaddr = 32'h0; end
      @(negedge clk);
      idle_inputs();
      case (act)
        A_EXC, A_IRQ, A_MRET: begin
          checks++; if (ctl !== ((act == A_MRET) ? 6'b101000 : 6'b110000)) begin errors++; $display("FAIL rnd%0d_n1: got %b act %0d", t, ctl, act); end
          @(negedge clk);
          checks++; if (ctl !== 6'b100100) begin errors++; $display("FAIL rnd%0d_n2: got %b expected %b", t, ctl, 6'b100100); end
          @(negedge clk);
        end
        A_WFI: begin
`ifdef TRAP_CTRL_WFI_EN
          checks++; if (ctl !== 6'b100010) begin errors++; $display("FAIL rnd%0d_wfi_stall: got %b expected %b", t, ctl, 6'b100010); end
          if (!pend_any) begin
            repeat (3) @(negedge clk);
            checks++; if (ctl !== 6'b100010) begin errors++; $display("FAIL rnd%0d_wfi_hold: got %b expected %b", t, ctl, 6'b100010); end
            mip = mip | 32'h8; mie = mie | 32'h8;
          end
          @(negedge clk);
`endif
          checks++; if (ctl !== 6'b000001) begin errors++; $display("FAIL rnd%0d_wake: got %b expected %b", t, ctl, 6'b000001); end
          @(negedge clk);
        end
        default: ;
      endcase
      checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL rnd%0d_idle: got %b expected 0", t, ctl); end
      checks++; if ({cause, pc, badaddr} !== {m_cause, m_pc, m_badaddr}) begin errors++; $display("FAIL rnd%0d_regs: got %h %h %h expected %h %h %h", t, cause, pc, badaddr, m_cause, m_pc, m_badaddr); end
      $display("txn %0d act=%0d cause=%h pc=%h badaddr=%h", t, act, m_cause, m_pc, m_badaddr);
    end
  endtask

  initial begin
    m_cause = 32'h0; m_pc = 32'h0; m_badaddr = 32'h0;
    test_reset();
    test_exception();
    test_irq_priority();
    test_masking_mret();
    test_simultaneous();
    test_back_to_back();
    test_wfi();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_controller.md
# trap_controller

Sequencer in front of `csr_exception_handler`: collects synchronous exceptions from the core, pending machine interrupts, `mret` and `wfi` requests, and arbitrates them into one trap action at a time. It drives the CSR unit's `exception_event`/`mret` pulses and the `cause`/`pc`/`badaddr` operands, then tells the core when the redirect target is valid. It sits between the control-unit FSM and the CSR/exception datapath.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flop stages on `irq_ext`; legal range 2..4.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `exc_valid`  in  1  core reports a synchronous exception on the current instruction
- `exc_code`  in  4  exception code, 0..15
- `exc_pc`  in  32  PC of the faulting instruction
- `exc_tval`  in  32  fault value; all-ones means "use PC"
- `insn_boundary`  in  1  core is between instructions, so an interrupt may be taken
- `next_pc`  in  32  PC of the next instruction to execute
- `mret_req`  in  1  `mret` decoded and legal
- `wfi_req`  in  1  `wfi` decoded
- `mstatus_mie`  in  1  `mstatus.MIE`
- `mie`  in  32  CSR `mie`
- `mip`  in  32  CSR `mip` (MSIP bit 3, MTIP bit 7)
- `irq_ext`  in  1  asynchronous external interrupt
- `meip`  out  1  synchronized `irq_ext`
- `exception_event`  out  1  one-cycle pulse to the CSR unit
- `mret`  out  1  one-cycle pulse to the CSR unit
- `cause`  out  32  registered trap cause
- `pc`  out  32  registered `mepc` source
- `badaddr`  out  32  registered `mtval` source
- `busy`  out  1  controller is sequencing; the core holds
- `trap_done`  out  1  one-cycle pulse; the CSR unit's `exception_next_pc` is valid and the core must load it
- `wfi_stall`  out  1  core is halted in WFI
- `wfi_wake`  out  1  one-cycle pulse; WFI is complete and the core advances

## Operation
- `pending = (mip | (meip << 11)) & mie & 32'h0000_0888`.
- `irq_take = insn_boundary & mstatus_mie & |pending`.
- Interrupt priority: MEI (11) > MSI (3) > MTI (7).
- Arbitration in IDLE, highest priority first: `exc_valid` > `irq_take` > `mret_req` > `wfi_req`. Only one request is accepted per cycle. Lower-priority requests are dropped; the core re-presents them.
- Exception accept registers:
  - `cause = {28'b0, exc_code}`
  - `pc = exc_pc`
  - `badaddr = exc_tval` (passed through unmodified)
- Interrupt accept registers:
  - `cause = {1'b1, 27'b0, code}` with `code` ∈ {11, 3, 7}
  - `pc = next_pc`
  - `badaddr = 32'b0`
- `mret` accept leaves `cause`/`pc`/`badaddr` unchanged.
- States:
  - IDLE: exception or interrupt → TRAP; `mret_req` → MRET; `wfi_req` → WFI.
  - TRAP: `exception_event = 1`; → REDIRECT.
  - MRET: `mret = 1`; → REDIRECT.
  - REDIRECT: `trap_done = 1`; → IDLE.
  - WFI: `wfi_stall = 1`; when `|pending` (independent of `mstatus_mie`), pulse `wfi_wake` → IDLE.
- `busy = (state != IDLE)`. All request inputs are ignored while busy.
- `meip` is the last stage of a `SYNC_STAGES`-deep shift register clocked by `clk`.

## Timing
- Reset values:
  - state = IDLE
  - all outputs 0
  - synchronizer stages 0
- Reset mid-sequence (TRAP, MRET, REDIRECT or WFI): return to IDLE on the next edge. No pulse is emitted after `rst` is sampled high.
- Request sampled in IDLE at edge N:
  - `exception_event`/`mret` high during cycle N+1.
  - `trap_done` high during cycle N+2.
  - IDLE again at N+3, so a new request can be accepted at edge N+3.
  - `busy` high for cycles N+1..N+2.
- `cause`/`pc`/`badaddr` are stable from N+1 until the next accept.
- WFI: `wfi_stall` is high from N+1. If `|pending` is sampled at edge M, `wfi_wake` is high and `wfi_stall` is low during cycle M+1. `wfi_wake` and `wfi_stall` are never both high.
- `irq_ext` reaches `meip` after `SYNC_STAGES` edges. It then needs one more edge to be arbitrated.
- `exc_valid` and `mret_req` in the same cycle: the exception wins and `mret` is not pulsed.
- An interrupt arriving while busy is taken at the first IDLE cycle with `insn_boundary`.

## Configuration
- `TRAP_CTRL_WFI_EN` defined: the WFI state is implemented as described above.
- Undefined: there is no WFI state. `wfi_req` accepted in IDLE produces a `wfi_wake` pulse the next cycle, with `busy` staying 0 and `wfi_stall` tied 0 (WFI acts as a NOP).

## Test plan
- Exception: `exc_valid=1`, `exc_code=2`, `exc_pc=0x100`, `exc_tval=0xDEAD` at edge N → `exception_event` at N+1 with `cause=0x2`, `pc=0x100`, `badaddr=0xDEAD`; `trap_done` at N+2; `busy` for 2 cycles.
- Interrupt priority: `mie=0x888`, `mip=0x88`, `irq_ext=1` held, `mstatus_mie=1`, `insn_boundary=1`, `next_pc=0x200` → once `meip` is set, `cause=0x8000_000B`, `pc=0x200`, `badaddr=0`; with `irq_ext=0`, `cause=0x8000_0003`.
- Masking: `mstatus_mie=0`, `mip=0x80`, `mie=0x80` → no trap; then `mret_req` → `mret` pulse at N+1, `trap_done` at N+2, `cause` unchanged.
- Simultaneous: `exc_valid`, `mret_req` and a pending interrupt in one cycle → exactly one `exception_event` with the exception cause; `mret` stays 0.
- WFI (macro on): `wfi_req` with `pending=0` → `wfi_stall` held 20 cycles; `mip=0x80` (`mie=0x80`, `mstatus_mie=0`) → `wfi_wake` pulse, back to IDLE. Macro off: `wfi_wake` one cycle after `wfi_req`, `busy=0`.
- Reset: assert `rst` during REDIRECT and during WFI → next cycle all outputs 0, state IDLE, no `trap_done`.
